// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and constants for the I2C transaction arbiter.
//   state_t  - sequencer FSM states
//   phase_t  - byte phases of a register transaction (A..E)
//   xact_t   - transaction fields latched from the winning requester
//   ST_*     - completion status codes, ADDR_* - address-byte R/W bit
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_PHASE, S_WAIT, S_STOP, S_STOPWAIT, S_DONE
  } state_t;

  // A: addr+W (start), B: register, C: write data,
  // D: addr+R (repeated start), E: read byte
  typedef enum logic [2:0] {
    PH_A, PH_B, PH_C, PH_D, PH_E
  } phase_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_TO   = 2'b10;

  localparam logic ADDR_W = 1'b0;
  localparam logic ADDR_R = 1'b1;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] rg;
    logic [7:0] wdata;
  } xact_t;

  function automatic logic last_phase(input phase_t p, input logic rw);
    return rw ? (p == PH_E) : (p == PH_C);
  endfunction

  function automatic phase_t next_phase(input phase_t p, input logic rw);
    phase_t n;
    case (p)
      PH_A:    n = PH_B;
      PH_B:    n = rw ? PH_D : PH_C;
      PH_D:    n = PH_E;
      default: n = PH_E;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     - request vector
//   last    - index of the previous winner; search starts at last+1 mod NREQ
//   advance - enables the pick; winner is all-zero when low
//   winner  - one-hot winner (zero if no request)
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  input  logic                    advance,
  output logic [NREQ-1:0]         winner
);

  localparam int LW = $clog2(NREQ);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (advance && !found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter/sequencer sharing one I2C master among
// NREQ requesters. Each granted transaction is split into byte phases on the
// master's start/stop/dataW/RW/go interface; status and read data return to
// the owner with a one-cycle done pulse.
//   clock, reset          - system clock, async active-high reset
//   req/req_rw/req_addr/req_reg/req_wdata - per-requester transaction
//   grant, done           - one-hot ownership and completion pulse
//   status, rdata         - completion status (OK/NACK/TO) and read byte
//   i2c_start/stop/RW/go/dataW - registered master command
//   i2c_ACK/NACK/TO/busy/dataR - master response
// Optional: define I2C_ARB_WATCHDOG_EN for a per-phase WDT_CYCLES watchdog.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WDT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_reg,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [1:0]        status,
  output logic [7:0]        rdata,
  output logic              i2c_start,
  output logic              i2c_stop,
  output logic              i2c_RW,
  output logic              i2c_go,
  output logic [7:0]        i2c_dataW,
  input  logic              i2c_ACK,
  input  logic              i2c_NACK,
  input  logic              i2c_TO,
  input  logic              i2c_busy,
  input  logic [7:0]        i2c_dataR
);

  localparam int LW = $clog2(NREQ);

  logic [NREQ-1:0][6:0] addr_p;
  logic [NREQ-1:0][7:0] reg_p;
  logic [NREQ-1:0][7:0] wdata_p;

  assign addr_p  = req_addr;
  assign reg_p   = req_reg;
  assign wdata_p = req_wdata;

  state_t          state;
  phase_t          phase;
  xact_t           xact;
  logic [LW-1:0]   last;
  logic [LW-1:0]   win_idx;
  logic [NREQ-1:0] win;
  logic            sw_first;   // first STOPWAIT cycle: master busy not yet visible
  logic [1:0]      st_r;
  logic [7:0]      rd_r;
  logic            wdt_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .last    (last),
    .advance (state == S_ARB),
    .winner  (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_idx = LW'(i);
  end

`ifdef I2C_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);

  logic [WW-1:0] wdt;
  logic          issue;
  logic          waiting;

  assign issue   = (state == S_PHASE && !i2c_busy) || (state == S_STOP);
  assign waiting = (state == S_WAIT) || (state == S_STOPWAIT);
  assign wdt_hit = waiting && (wdt == WW'(WDT_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    wdt <= '0;
    else if (issue)               wdt <= '0;
    else if (waiting && !wdt_hit) wdt <= wdt + 1'b1;
  end
`else
  // No watchdog: completion relies on the master's own timeout.
  assign wdt_hit = 1'b0 && (WDT_CYCLES != 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= PH_A;
      xact      <= '0;
      last      <= LW'(NREQ - 1);
      grant     <= '0;
      done      <= '0;
      status    <= ST_OK;
      rdata     <= '0;
      i2c_start <= 1'b0;
      i2c_stop  <= 1'b0;
      i2c_RW    <= 1'b0;
      i2c_go    <= 1'b0;
      i2c_dataW <= '0;
      sw_first  <= 1'b0;
      st_r      <= ST_OK;
      rd_r      <= '0;
    end else begin
      i2c_go <= 1'b0;
      done   <= '0;
      unique case (state)
        S_IDLE: if (|req) state <= S_ARB;

        S_ARB: begin
          if (|win) begin
            xact.rw    <= req_rw[win_idx];
            xact.addr  <= addr_p[win_idx];
            xact.rg    <= reg_p[win_idx];
            xact.wdata <= wdata_p[win_idx];
            grant      <= win;
            last       <= win_idx;
            phase      <= PH_A;
            st_r       <= ST_OK;
            rd_r       <= '0;
            state      <= S_PHASE;
          end else begin
            state <= S_IDLE;
          end
        end

        S_PHASE: begin
          if (!i2c_busy) begin
            i2c_go   <= 1'b1;
            i2c_stop <= 1'b0;
            unique case (phase)
              PH_A: begin
                i2c_start <= 1'b1;
                i2c_RW    <= 1'b0;
                i2c_dataW <= {xact.addr, ADDR_W};
              end
              PH_B: begin
                i2c_start <= 1'b0;
                i2c_RW    <= 1'b0;
                i2c_dataW <= xact.rg;
              end
              PH_C: begin
                i2c_start <= 1'b0;
                i2c_RW    <= 1'b0;
                i2c_dataW <= xact.wdata;
              end
              PH_D: begin
                i2c_start <= 1'b1;
                i2c_RW    <= 1'b0;
                i2c_dataW <= {xact.addr, ADDR_R};
              end
              default: begin
                i2c_start <= 1'b0;
                i2c_RW    <= 1'b1;
                i2c_dataW <= 8'hFF;
              end
            endcase
            state <= S_WAIT;
          end
        end

        // TO beats NACK beats ACK when several arrive together
        S_WAIT: begin
          if (i2c_TO || wdt_hit) begin
            st_r  <= ST_TO;
            state <= S_STOP;
          end else if (i2c_NACK) begin
            st_r  <= ST_NACK;
            state <= S_STOP;
          end else if (i2c_ACK) begin
            if (phase == PH_E) rd_r <= i2c_dataR;
            if (last_phase(phase, xact.rw)) begin
              state <= S_STOP;
            end else begin
              phase <= next_phase(phase, xact.rw);
              state <= S_PHASE;
            end
          end
        end

        S_STOP: begin
          i2c_go    <= 1'b1;
          i2c_start <= 1'b0;
          i2c_stop  <= 1'b1;
          i2c_RW    <= 1'b0;
          sw_first  <= 1'b1;
          state     <= S_STOPWAIT;
        end

        // done is registered here so it appears one cycle after busy falls
        S_STOPWAIT: begin
          sw_first <= 1'b0;
          if (wdt_hit) begin
            done   <= grant;
            status <= ST_TO;
            rdata  <= '0;
            state  <= S_DONE;
          end else if (!sw_first && !i2c_busy) begin
            done   <= grant;
            status <= st_r;
            rdata  <= (st_r == ST_OK && xact.rw) ? rd_r : 8'h00;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          grant <= '0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: self-checking bench for i2c_arbiter with a behavioural
// I2C master model and a transaction-level expected-byte reference.
module tb_i2c_arbiter;

  localparam int NREQ = 2;
`ifdef I2C_ARB_WATCHDOG_EN
  localparam int WDT = 100;
`else
  localparam int WDT = 65535;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [8*NREQ-1:0] req_reg = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   grant, done;
  logic [1:0]        status;
  logic [7:0]        rdata;
  logic              i2c_start, i2c_stop, i2c_RW, i2c_go;
  logic [7:0]        i2c_dataW;
  logic              i2c_ACK = 1'b0, i2c_NACK = 1'b0, i2c_TO = 1'b0;
  logic              m_busy = 1'b0, ext_busy = 1'b0;
  logic              i2c_busy;
  logic [7:0]        i2c_dataR = '0;

  assign i2c_busy = m_busy | ext_busy;

  i2c_arbiter #(.NREQ(NREQ), .WDT_CYCLES(WDT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_reg(req_reg), .req_wdata(req_wdata),
    .grant(grant), .done(done), .status(status), .rdata(rdata),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_RW(i2c_RW),
    .i2c_go(i2c_go), .i2c_dataW(i2c_dataW), .i2c_ACK(i2c_ACK),
    .i2c_NACK(i2c_NACK), .i2c_TO(i2c_TO), .i2c_busy(i2c_busy),
    .i2c_dataR(i2c_dataR)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int onehot_err = 0;
  int grant_done_err = 0;

  // master model controls: byte index plan_at gets response kind plan_kind
  // kinds: 0 ACK, 1 NACK, 2 TO, 3 ACK+NACK, 4 TO+NACK, 5 TO+ACK
  int         plan_at = -1;
  int         plan_kind = 0;
  bit         mute = 1'b0;
  logic [7:0] rd_val = '0;
  int         bidx = 0;
  logic [10:0] log_q[$];
  int          go_cyc[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // behavioural I2C master
  initial begin
    int k;
    forever begin
      @(posedge clock); #1;
      if (i2c_go) begin
        log_q.push_back({i2c_start, i2c_stop, i2c_RW, i2c_dataW});
        go_cyc.push_back(cyc);
        m_busy = 1'b1;
        repeat (2 + $urandom_range(0, 3)) begin @(posedge clock); #1; end
        if (i2c_stop || mute) begin
          m_busy = 1'b0;
        end else begin
          k = (bidx == plan_at) ? plan_kind : 0;
          i2c_ACK   = (k == 0 || k == 3 || k == 5);
          i2c_NACK  = (k == 1 || k == 3 || k == 4);
          i2c_TO    = (k == 2 || k == 4 || k == 5);
          i2c_dataR = i2c_RW ? rd_val : 8'($urandom);
          m_busy    = 1'b0;
          bidx++;
          @(posedge clock); #1;
          i2c_ACK = 1'b0; i2c_NACK = 1'b0; i2c_TO = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if ($countones(grant) > 1) onehot_err++;
    if (|done && grant !== done) grant_done_err++;
  end

  function automatic logic [10:0] exp_byte(input int k, input bit rw, input logic [6:0] a,
                                           input logic [7:0] r, input logic [7:0] w);
    case (k)
      0:       return {3'b100, a, 1'b0};
      1:       return {3'b000, r};
      2:       return rw ? {3'b100, a, 1'b1} : {3'b000, w};
      default: return {3'b001, 8'hFF};
    endcase
  endfunction

  task automatic set_fields(input int idx, input bit rw, input logic [6:0] a,
                            input logic [7:0] r, input logic [7:0] w);
    req_rw[idx]          = rw;
    req_addr[7*idx +: 7] = a;
    req_reg[8*idx +: 8]  = r;
    req_wdata[8*idx +: 8] = w;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (|done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic run_one(input string nm, input int idx, input bit rw, input logic [6:0] a,
                         input logic [7:0] r, input logic [7:0] w, input int at,
                         input int kind, input logic [7:0] rd, input int hold_busy);
    int nb, nsent, gos;
    bit seen, got;
    logic [1:0] est;
    set_fields(idx, rw, a, r, w);
    plan_at = at; plan_kind = kind; rd_val = rd; bidx = 0;
    log_q.delete(); go_cyc.delete();
    @(negedge clock);
    ext_busy = (hold_busy > 0);
    req[idx] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (grant[idx]) begin got = 1'b1; break; end
    end
    chk({nm, "_grant"}, {31'd0, got}, 32'd1);
    req[idx] = 1'b0;
    if (hold_busy > 0) begin
      gos = 0;
      repeat (hold_busy) begin @(negedge clock); if (i2c_go) gos++; end
      chk({nm, "_no_go_busy"}, gos, 0);
      ext_busy = 1'b0;
    end
    wait_done(seen);
    chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
    nb    = rw ? 4 : 3;
    nsent = (kind != 0 && at < nb) ? at + 1 : nb;
    if (kind == 0 || at >= nb) est = 2'b00;
    else if (kind == 1 || kind == 3) est = 2'b01;
    else est = 2'b10;
    chk({nm, "_done"}, done, 32'(1 << idx));
    chk({nm, "_status"}, status, est);
    chk({nm, "_rdata"}, rdata, (est == 2'b00 && rw) ? rd : 8'h00);
    chk({nm, "_nbytes"}, log_q.size(), nsent + 1);
    for (int i = 0; i < nsent && i < log_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), log_q[i], exp_byte(i, rw, a, r, w));
    if (log_q.size() == nsent + 1)
      chk({nm, "_stop"}, log_q[nsent][10:9], 2'b01);
    repeat (3) @(negedge clock);
    chk({nm, "_hold"}, {status, rdata}, {est, (est == 2'b00 && rw) ? rd : 8'h00});
    chk({nm, "_idle"}, {grant, done}, '0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clock);
    chk("reset_outs", {grant, done, status, rdata, i2c_start, i2c_stop, i2c_RW, i2c_go, i2c_dataW}, '0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_one("wr", 0, 1'b0, 7'h50, 8'h10, 8'hA5, -1, 0, 8'h00, 0);
    run_one("rd", 1, 1'b1, 7'h68, 8'h75, 8'h00, -1, 0, 8'h71, 0);
    run_one("nack_addr", 0, 1'b0, 7'h50, 8'h10, 8'hA5, 0, 1, 8'h00, 0);
    run_one("busy", 0, 1'b0, 7'h22, 8'h33, 8'h44, -1, 0, 8'h00, 20);
    run_one("ack_nack", 1, 1'b1, 7'h11, 8'h01, 8'h00, 2, 3, 8'h5A, 0);
    run_one("to_ack", 0, 1'b1, 7'h12, 8'h02, 8'h00, 3, 5, 8'h5A, 0);

    // reset while waiting for a response
    mute = 1'b1;
    set_fields(1, 1'b1, 7'h68, 8'h75, 8'h00);
    req[1] = 1'b1;
    repeat (4) @(negedge clock);
    req[1] = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {grant, done, status, rdata, i2c_start, i2c_stop, i2c_RW, i2c_go, i2c_dataW}, '0);
    seen = 1'b0;
    repeat (5) begin @(negedge clock); if (|done) seen = 1'b1; end
    reset = 1'b0;
    mute = 1'b0;
    repeat (10) @(negedge clock);
    if (|done) seen = 1'b1;
    chk("rst_mid_no_done", {31'd0, seen}, 32'd0);

    // both requesters held: requester 0 first, then strict alternation
    plan_at = -1; plan_kind = 0;
    set_fields(0, 1'b0, 7'h01, 8'h02, 8'h03);
    set_fields(1, 1'b0, 7'h04, 8'h05, 8'h06);
    @(negedge clock);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_done(seen);
      chk($sformatf("rr_seen%0d", t), {31'd0, seen}, 32'd1);
      chk($sformatf("rr_order%0d", t), done, (t % 2 == 0) ? 32'd1 : 32'd2);
    end
    req = 2'b00;
    repeat (10) @(negedge clock);

    for (int t = 0; t < 24; t++) begin
      int idx, at, kind, nb;
      bit rw;
      idx = $urandom_range(0, NREQ - 1);
      rw  = 1'($urandom_range(0, 1));
      nb  = rw ? 4 : 3;
      if ($urandom_range(0, 2) == 0) begin
        at = $urandom_range(0, nb - 1); kind = $urandom_range(1, 5);
      end else begin
        at = -1; kind = 0;
      end
      run_one($sformatf("rnd%0d", t), idx, rw, 7'($urandom), 8'($urandom), 8'($urandom),
              at, kind, 8'($urandom), 0);
    end

`ifdef I2C_ARB_WATCHDOG_EN
    mute = 1'b1;
    log_q.delete(); go_cyc.delete();
    set_fields(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    req[0] = 1'b1;
    repeat (4) @(negedge clock);
    req[0] = 1'b0;
    wait_done(seen);
    chk("wdt_done", {31'd0, seen}, 32'd1);
    chk("wdt_status", status, 2'b10);
    chk("wdt_nbytes", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("wdt_stop", log_q[1][10:9], 2'b01);
      chk("wdt_gap", ((go_cyc[1] - go_cyc[0]) >= 100 && (go_cyc[1] - go_cyc[0]) <= 105), 1);
    end
    mute = 1'b0;
`endif

    chk("onehot_grant", onehot_err, 0);
    chk("grant_with_done", grant_done_err, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
